// File: rtl/inv_dir_scheduler.sv
// Round-robin arbiter and sequencer that shares one 1/dir divider among NUM_REQ
// traversal lanes; skip-flagged rays bypass the divider and return zero.
module inv_dir_scheduler #(
    parameter int WIDTH   = 16,
    parameter int Q_BITS  = 12,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*3*WIDTH-1:0]     req_dir,
    input  logic [NUM_REQ-1:0]             req_skip,
    output logic                           div_start,
    output logic [3*WIDTH-1:0]             div_dir,
    input  logic                           div_valid,
    input  logic [3*WIDTH-1:0]             div_dir_inv,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     resp_id,
    output logic [3*WIDTH-1:0]             resp_dir_inv,
    output logic                           resp_skip,
    output logic                           resp_err,
    output logic                           busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int DIR_W = 3 * WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("inv_dir_scheduler: NUM_REQ must be 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("inv_dir_scheduler: TIMEOUT must be >= 2");
    end
    if (Q_BITS >= WIDTH) begin : g_bad_qbits
        $error("inv_dir_scheduler: Q_BITS must be below WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [DIR_W-1:0]  r_dir;
    logic [DIR_W-1:0]  r_dir_inv;
    logic              r_skip;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_grant_found;
    logic [ID_W-1:0]   w_grant_id;
    logic [ID_W:0]     w_idx;
    logic [DIR_W-1:0]  w_grant_dir;
    logic              w_timeout;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // First valid requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
            if (w_idx >= (ID_W + 1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!w_grant_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_grant_dir = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_grant_dir = req_dir[i*DIR_W +: DIR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        div_start   = 1'b0;
        div_dir     = '0;
        resp_valid  = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_grant_found && !reset) begin
                    req_ready[w_grant_id] = 1'b1;
                    w_state_nxt = req_skip[w_grant_id] ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_start   = 1'b1;
                div_dir     = r_dir;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                div_dir = r_dir;
                if (div_valid || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                div_dir    = r_dir;
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_dir     <= '0;
            r_dir_inv <= '0;
            r_skip    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_id      <= w_grant_id;
                        r_dir     <= w_grant_dir;
                        r_skip    <= req_skip[w_grant_id];
                        r_dir_inv <= '0;
                        r_err     <= 1'b0;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A result arriving on the last WAIT cycle beats the timeout.
                    if (div_valid) begin
                        r_dir_inv <= div_dir_inv;
                        r_err     <= 1'b0;
                    end else if (w_timeout) begin
                        r_dir_inv <= '0;
                        r_err     <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_rr_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_id      = r_id;
    assign resp_dir_inv = r_dir_inv;
    assign resp_skip    = r_skip;
    assign resp_err     = r_err;

endmodule

// File: doc/inv_dir_scheduler.md
# inv_dir_scheduler

Arbitration and sequencing controller for the shared `NR_inv_dir_block` 1/dir divider unit. Up to NUM_REQ ray sources (traversal lanes) request reciprocal ray directions. The scheduler:
- grants one request at a time, round-robin;
- pulses the divider start and waits for its valid, with a timeout guard;
- returns the result with the requester ID over a valid/ready response port.

Skip-flagged rays bypass the divider entirely.

## Interface
- WIDTH, 16, fixed-point word width per component
- Q_BITS, 12, fractional bits (Q3.12)
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max WAIT cycles before abort (≥ 2)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_dir  in  NUM_REQ×3×WIDTH  per-requester RayDirection {x,y,z}
- req_skip  in  NUM_REQ  per-requester skip flag
- div_start  out  1  one-cycle start pulse to divider
- div_dir  out  3×WIDTH  RayDirection driven to divider, held stable through WAIT
- div_valid  in  1  divider result valid
- div_dir_inv  in  3×WIDTH  divider reciprocal result
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  $clog2(NUM_REQ)  index of served requester
- resp_dir_inv  out  3×WIDTH  reciprocal direction
- resp_skip  out  1  skip flag of served ray
- resp_err  out  1  divider timed out
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant = first index with req_valid set, searching from rr_ptr upward with wrap.
  - req_ready is asserted only at the grant index.
  - On handshake: latch id, dir and skip.
  - skip=1 → RESP with resp_dir_inv=0 and resp_skip=1; div_start is never asserted.
  - skip=0 → ISSUE.
- **ISSUE**
  - div_start=1 for exactly one cycle; div_dir = latched dir.
  - Clear timeout counter; → WAIT.
- **WAIT**
  - Counter increments each cycle.
  - div_valid=1 → capture div_dir_inv into resp_dir_inv, resp_err=0, → RESP.
  - Counter reaches TIMEOUT−1 without div_valid → resp_dir_inv=0, resp_err=1, → RESP.
  - If div_valid and timeout fall in the same cycle, div_valid wins (err=0).
- **RESP**
  - resp_valid=1; resp_* fields are held stable until resp_ready.
  - On handshake: rr_ptr ← (id+1) mod NUM_REQ, → IDLE.
- div_valid outside WAIT is ignored; no state change and no capture.
- req_ready is 0 in all states except IDLE. Requests arriving during service stay pending; requesters must hold valid and data until accepted.
- div_dir holds the latched value from ISSUE through RESP; its value in IDLE is don't-care, driven 0.
- rr_ptr resets to 0. Pointer arithmetic wraps at NUM_REQ, including non-power-of-2 values.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, counter=0
  - req_ready=0 while reset is high
  - div_start=0, div_dir=0
  - resp_valid=0, resp_id=0, resp_dir_inv=0, resp_skip=0, resp_err=0
  - busy=0
- Reset mid-operation: abandons the in-flight ray with no response. The divider is reset by the same reset line.
- Request handshake at cycle T (non-skip):
  - div_start at T+1.
  - Divider valid at T+1+L.
  - resp_valid at T+2+L.
- Skip handshake at T: resp_valid at T+1.
- Timeout: resp_valid with err at T+2+TIMEOUT.
- Back-to-back: a response handshake at cycle R lets a new grant occur at R+1 (IDLE). Minimum issue interval is L+3 cycles.
- Only one ray is outstanding at any time.

## Test plan
- **Single non-skip request.** req0 with dir {0x1000,0x2000,0x0800}, divider model L=29.
  - One div_start at T+1.
  - resp_valid at T+31: id=0, dir_inv {0x1000,0x0800,0x2000}, err=0.
- **Skip bypass.** req2 with skip=1.
  - No div_start.
  - resp_valid at T+1: id=2, dir_inv=0, skip=1.
- **Round-robin fairness.** All four requesters held valid.
  - Grant order 0,1,2,3,0.
  - After serving 1 with only 0 and 3 pending, next grant is 3.
- **Backpressure.** resp_ready held low 10 cycles.
  - resp_* stable throughout; no new req_ready.
  - Grant occurs the cycle after the resp handshake.
- **Timeout.** Divider never asserts valid, TIMEOUT=64.
  - resp_valid at T+66, err=1, dir_inv=0.
  - A stray div_valid the following cycle is ignored.
- **Reset in WAIT.** Reset asserted during WAIT.
  - All outputs 0 on the next edge, state IDLE, rr_ptr=0, no response emitted.
